// File: rtl/cacheline_adaptor_p_pkg.sv
// Shared geometry and FSM encoding for the cacheline <-> burst memory adaptor.
package cacheline_adaptor_p_pkg;

  localparam int unsigned LINE_WIDTH  = 256;
  localparam int unsigned BURST_WIDTH = 64;
  localparam int unsigned ADDR_WIDTH  = 32;
  localparam int unsigned OFFSET_BITS = 5;
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int unsigned BEAT_IDX_W  = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor_p_line_shift_buf.sv
// Beat-addressable cacheline buffer: whole-line load for writebacks, per-beat
// load for fills, and a per-beat read port feeding the write burst.
module cacheline_adaptor_p_line_shift_buf #(
  parameter  int unsigned LINE_WIDTH  = 256,
  parameter  int unsigned BURST_WIDTH = 64,
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH,
  localparam int unsigned IDX_W       = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_line_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  input  logic                   load_beat_i,
  input  logic [IDX_W-1:0]       load_idx_i,
  input  logic [BURST_WIDTH-1:0] beat_i,
  input  logic [IDX_W-1:0]       sel_idx_i,
  output logic [BURST_WIDTH-1:0] sel_beat_c_o,
  output logic [LINE_WIDTH-1:0]  line_o
);

  logic [BEATS-1:0][BURST_WIDTH-1:0] lbuf_q;
  logic [BEATS-1:0][BURST_WIDTH-1:0] lbuf_d;

  // Whole-line load takes priority; the FSM never requests both together.
  always_comb begin
    lbuf_d = lbuf_q;
    if (load_line_i) begin
      lbuf_d = line_i;
    end else if (load_beat_i) begin
      lbuf_d[load_idx_i] = beat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lbuf_q <= '0;
    end else begin
      lbuf_q <= lbuf_d;
    end
  end

  assign sel_beat_c_o = lbuf_q[sel_idx_i];
  assign line_o       = lbuf_q;

endmodule

// File: rtl/cacheline_adaptor_p.sv
// Converts one cacheline fill/writeback into a BEATS-long burst on the memory port.
// Define ADAPTOR_EARLY_RESP_EN to raise line_resp_o combinationally with the final beat and skip DONE.
module cacheline_adaptor_p #(
  parameter  int unsigned LINE_WIDTH  = 256,
  parameter  int unsigned BURST_WIDTH = 64,
  parameter  int unsigned ADDR_WIDTH  = 32,
  parameter  int unsigned OFFSET_BITS = 5,
  localparam int unsigned BEATS       = LINE_WIDTH / BURST_WIDTH,
  localparam int unsigned BEAT_IDX_W  = $clog2(BEATS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   line_read_i,
  input  logic                   line_write_i,
  input  logic [ADDR_WIDTH-1:0]  line_addr_i,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  output logic                   line_resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  mem_addr_o,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  input  logic                   mem_resp_i
);

  import cacheline_adaptor_p_pkg::*;

`ifdef ADAPTOR_EARLY_RESP_EN
  localparam bit EARLY_RESP = 1'b1;
`else
  localparam bit EARLY_RESP = 1'b0;
`endif

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT   = BEAT_IDX_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  adaptor_state_t state_q, state_d;

  logic [BEAT_IDX_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic                   resp_q, resp_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [LINE_WIDTH-1:0]  line_q, line_d;

  logic                   buf_load_line;
  logic                   buf_load_beat;
  logic [BEAT_IDX_W-1:0]  sel_idx;
  logic [BURST_WIDTH-1:0] sel_beat;
  logic [LINE_WIDTH-1:0]  buf_line;
  logic [LINE_WIDTH-1:0]  fill_line;
  logic                   beat_ok;
  logic                   last_beat;

  // One beat moves per cycle the memory responds while a request is up.
  assign beat_ok   = mem_resp_i & (mem_read_q | mem_write_q);
  assign last_beat = beat_ok & (cnt_q == LAST_BEAT);
  assign sel_idx   = cnt_q + BEAT_IDX_W'(1);

  // Completed fill: the top beat arrives on burst_i in the same cycle it is accepted.
  always_comb begin
    fill_line = buf_line;
    fill_line[LINE_WIDTH-1 -: BURST_WIDTH] = burst_i;
  end

  cacheline_adaptor_p_line_shift_buf #(
    .LINE_WIDTH  (LINE_WIDTH),
    .BURST_WIDTH (BURST_WIDTH)
  ) u_line_buf (
    .clk          (clk),
    .rst          (rst),
    .load_line_i  (buf_load_line),
    .line_i       (line_i),
    .load_beat_i  (buf_load_beat),
    .load_idx_i   (cnt_q),
    .beat_i       (burst_i),
    .sel_idx_i    (sel_idx),
    .sel_beat_c_o (sel_beat),
    .line_o       (buf_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only sampled in IDLE, so a request still held during DONE is not reissued.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (line_write_i) begin
          state_d = WRITE;
        end else if (line_read_i) begin
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (last_beat) begin
          state_d = EARLY_RESP ? IDLE : DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d         = cnt_q;
    addr_d        = addr_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    resp_d        = 1'b0;
    burst_d       = burst_q;
    line_d        = line_q;
    buf_load_line = 1'b0;
    buf_load_beat = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write_i) begin
          addr_d        = line_addr_i & ~OFFSET_MASK;
          cnt_d         = '0;
          mem_write_d   = 1'b1;
          burst_d       = line_i[BURST_WIDTH-1:0];
          buf_load_line = 1'b1;
        end else if (line_read_i) begin
          addr_d     = line_addr_i & ~OFFSET_MASK;
          cnt_d      = '0;
          mem_read_d = 1'b1;
        end
      end
      READ: begin
        if (beat_ok) begin
          buf_load_beat = 1'b1;
          cnt_d         = cnt_q + BEAT_IDX_W'(1);
          if (last_beat) begin
            mem_read_d = 1'b0;
            line_d     = fill_line;
            resp_d     = ~EARLY_RESP;
          end
        end
      end
      WRITE: begin
        if (beat_ok) begin
          cnt_d   = cnt_q + BEAT_IDX_W'(1);
          burst_d = sel_beat;
          if (last_beat) begin
            mem_write_d = 1'b0;
            resp_d      = ~EARLY_RESP;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      resp_q      <= 1'b0;
      burst_q     <= '0;
      line_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      resp_q      <= resp_d;
      burst_q     <= burst_d;
      line_q      <= line_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign burst_o     = burst_q;
  assign line_resp_o = EARLY_RESP ? last_beat : resp_q;
  assign line_o      = (EARLY_RESP && (state_q == READ) && last_beat) ? fill_line : line_q;

`ifndef SYNTHESIS
  // Protocol monitors: these are warnings, the hardware resolves both cases deterministically.
  always @(posedge clk) begin
    if (!rst && (state_q == IDLE)) begin
      assert (!(line_read_i && line_write_i))
        else $warning("simultaneous line read and write request, servicing the write");
    end
    if (!rst && ((state_q == IDLE) || (state_q == DONE))) begin
      assert (!mem_resp_i)
        else $warning("mem_resp_i outside a burst is ignored");
    end
  end
`endif

endmodule

// File: tb/tb_cacheline_adaptor_p.sv
// Directed self-checking bench for cacheline_adaptor_p (both response timings).
module tb_cacheline_adaptor_p;

  localparam int unsigned LW = 256;
  localparam int unsigned BW = 64;
  localparam int unsigned AW = 32;

`ifdef ADAPTOR_EARLY_RESP_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          line_read_i;
  logic          line_write_i;
  logic [AW-1:0] line_addr_i;
  logic [LW-1:0] line_i;
  logic [LW-1:0] line_o;
  logic          line_resp_o;
  logic [BW-1:0] burst_i;
  logic [BW-1:0] burst_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_read_o;
  logic          mem_write_o;
  logic          mem_resp_i;

  int checks = 0;
  int errors = 0;
  int resp_cnt = 0;
  int rd_starts = 0;
  int wr_starts = 0;
  logic rd_prev = 1'b0;
  logic wr_prev = 1'b0;

  localparam logic [LW-1:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                  64'h2222222222222222, 64'h1111111111111111};
  localparam logic [LW-1:0] LW2 = {64'h0123456789ABCDEF, 64'h1032547698BADCFE,
                                   64'hFEDCBA9876543210, 64'hA5A55A5A0123CDEF};
  localparam logic [LW-1:0] LW3 = {64'hC3C3C3C3C3C3C3C3, 64'hB2B2B2B2B2B2B2B2,
                                   64'hA1A1A1A1A1A1A1A1, 64'h9090909090909090};
  localparam logic [LW-1:0] LW4 = {64'h0000000400000004, 64'h0000000300000003,
                                   64'h0000000200000002, 64'h0000000100000001};
  localparam logic [LW-1:0] L4 = {64'hDEADBEEF00000004, 64'hDEADBEEF00000003,
                                  64'hDEADBEEF00000002, 64'hDEADBEEF00000001};
  localparam logic [LW-1:0] L5 = {64'h0F0F0F0F0F0F0F0F, 64'hF0F0F0F0F0F0F0F0,
                                  64'h5555555555555555, 64'hAAAAAAAAAAAAAAAA};

  cacheline_adaptor_p dut (
    .clk          (clk),
    .rst          (rst),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_addr_i  (line_addr_i),
    .line_i       (line_i),
    .line_o       (line_o),
    .line_resp_o  (line_resp_o),
    .burst_i      (burst_i),
    .burst_o      (burst_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_resp_i   (mem_resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts completion pulses and memory transaction starts.
  always @(posedge clk) begin
    if (line_resp_o) resp_cnt <= resp_cnt + 1;
    if (mem_read_o && !rd_prev) rd_starts <= rd_starts + 1;
    if (mem_write_o && !wr_prev) wr_starts <= wr_starts + 1;
    rd_prev <= mem_read_o;
    wr_prev <= mem_write_o;
  end

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Zero-wait fill; request held until the cycle after line_resp_o.
  task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                         input logic [LW-1:0] exp_line, input logic [LW-1:0] prev_line);
    int r0;
    r0 = resp_cnt;
    @(negedge clk);
    line_read_i = 1'b1;
    line_addr_i = addr;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk({tag, "_rd_req"}, mem_read_o, 1);
      chk({tag, "_wr_idle"}, mem_write_o, 0);
      chk({tag, "_addr"}, mem_addr_o, exp_addr);
      mem_resp_i = 1'b1;
      burst_i    = exp_line[(c-1)*BW +: BW];
      #1;
      if (c == 4) begin
        chk({tag, "_resp_beat3"}, line_resp_o, EARLY);
        chk({tag, "_line_beat3"}, line_o, EARLY ? exp_line : prev_line);
      end
    end
    @(negedge clk);
    mem_resp_i = 1'b0;
    burst_i    = '0;
    chk({tag, "_rd_drop"}, mem_read_o, 0);
    chk({tag, "_resp_done"}, line_resp_o, !EARLY);
    chk({tag, "_line"}, line_o, exp_line);
    line_read_i = !EARLY;
    @(negedge clk);
    line_read_i = 1'b0;
    chk({tag, "_resp_clear"}, line_resp_o, 0);
    chk({tag, "_line_hold"}, line_o, exp_line);
    @(negedge clk);
    chk({tag, "_no_reissue"}, mem_read_o, 0);
    chk({tag, "_one_resp"}, resp_cnt - r0, 1);
  endtask

  // Writeback with a per-cycle mem_resp_i pattern (bit c-1 drives cycle c).
  task automatic do_write(input string tag, input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                          input logic [LW-1:0] wline, input logic both,
                          input logic [15:0] pat, input int plen);
    int r0;
    int beat;
    r0   = resp_cnt;
    beat = 0;
    @(negedge clk);
    line_write_i = 1'b1;
    line_read_i  = both;
    line_addr_i  = addr;
    line_i       = wline;
    for (int c = 1; c <= plen; c++) begin
      @(negedge clk);
      chk({tag, "_wr_req"}, mem_write_o, 1);
      chk({tag, "_rd_idle"}, mem_read_o, 0);
      chk({tag, "_addr"}, mem_addr_o, exp_addr);
      chk({tag, "_burst"}, burst_o, wline[beat*BW +: BW]);
      mem_resp_i = pat[c-1];
      #1;
      if (pat[c-1]) begin
        chk({tag, "_resp_beat"}, line_resp_o, (beat == 3) ? EARLY : 1'b0);
        beat++;
      end
    end
    @(negedge clk);
    mem_resp_i = 1'b0;
    chk({tag, "_wr_drop"}, mem_write_o, 0);
    chk({tag, "_resp_done"}, line_resp_o, !EARLY);
    line_write_i = !EARLY;
    line_read_i  = both & !EARLY;
    @(negedge clk);
    line_write_i = 1'b0;
    line_read_i  = 1'b0;
    chk({tag, "_resp_clear"}, line_resp_o, 0);
    @(negedge clk);
    chk({tag, "_no_reissue_wr"}, mem_write_o, 0);
    chk({tag, "_no_read"}, mem_read_o, 0);
    chk({tag, "_one_resp"}, resp_cnt - r0, 1);
  endtask

  initial begin
    int rd0;
    int wr0;
    int rs0;
    rst          = 1'b1;
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    line_addr_i  = '0;
    line_i       = '0;
    burst_i      = '0;
    mem_resp_i   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_line_o", line_o, 0);
    chk("rst_resp", line_resp_o, 0);
    chk("rst_burst", burst_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_mem_read", mem_read_o, 0);
    chk("rst_mem_write", mem_write_o, 0);
    rst = 1'b0;

    do_read("t1", 32'h0000_12A4, 32'h0000_12A0, L1, '0);

    do_write("t2", 32'h0000_0A5F, 32'h0000_0A40, LW2, 1'b0, 16'b0000_0000_0101_1001, 7);
    chk("t2_line_o_stable", line_o, L1);

    rd0 = rd_starts;
    wr0 = wr_starts;
    do_write("t3", 32'h0000_03C8, 32'h0000_03C0, LW3, 1'b1, 16'h000F, 4);
    chk("t3_no_read_txn", rd_starts - rd0, 0);
    chk("t3_one_write_txn", wr_starts - wr0, 1);

    rd0 = rd_starts;
    wr0 = wr_starts;
    rs0 = resp_cnt;
    do_write("t4w", 32'h0000_0100, 32'h0000_0100, LW4, 1'b0, 16'h000F, 4);
    do_read("t4r", 32'h0000_0200, 32'h0000_0200, L4, L1);
    chk("t4_read_txns", rd_starts - rd0, 1);
    chk("t4_write_txns", wr_starts - wr0, 1);
    chk("t4_resp_pulses", resp_cnt - rs0, 2);

    rs0 = resp_cnt;
    @(negedge clk);
    line_read_i = 1'b1;
    line_addr_i = 32'h0000_0080;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk("t5_rd_req", mem_read_o, 1);
      mem_resp_i = 1'b1;
      burst_i    = {16{4'(c)}};
    end
    @(negedge clk);
    rst         = 1'b1;
    mem_resp_i  = 1'b0;
    line_read_i = 1'b0;
    burst_i     = '0;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_line_o", line_o, 0);
    chk("t5_resp", line_resp_o, 0);
    chk("t5_burst", burst_o, 0);
    chk("t5_addr", mem_addr_o, 0);
    chk("t5_mem_read", mem_read_o, 0);
    chk("t5_mem_write", mem_write_o, 0);
    @(negedge clk);
    chk("t5_no_resp", resp_cnt - rs0, 0);
    do_read("t5r", 32'h0000_0040, 32'h0000_0040, L5, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
